// File: rtl/counter_pkg.sv
//------------------------------------------------------------------------------
// Module   : counter_pkg
// Brief    : Shared types and the operation priority decoder for
//            updown_mod_counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DOWN = 2'd3
    } counter_op_t;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_OVF  = 2'd1,
        EV_UNF  = 2'd2
    } counter_evt_t;

    // load wins; up and down together cancel to a hold
    function automatic counter_op_t decode_op(input logic ld, input logic up, input logic dn);
        counter_op_t op;
        if (ld)
            op = OP_LOAD;
        else if (up && dn)
            op = OP_HOLD;
        else if (up)
            op = OP_UP;
        else if (dn)
            op = OP_DOWN;
        else
            op = OP_HOLD;
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter_next_calc.sv
//------------------------------------------------------------------------------
// Module   : counter_next_calc
// Brief    : Combinational next-count and overflow/underflow event generator.
//            Saturation is available only when UDCOUNTER_SAT_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module counter_next_calc
    import counter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STEP_WIDTH = 4
) (
    input  logic                  clk_unused_tie,
    input  counter_op_t           op,
    input  logic [DATA_WIDTH-1:0] dout,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [DATA_WIDTH-1:0] limit,
    input  logic                  sat,
    output logic [DATA_WIDTH-1:0] nxt,
    output counter_evt_t          evt
);

    localparam int c_W1 = DATA_WIDTH + 1;

    logic             w_sat_en;
    logic [c_W1-1:0]  w_dout_x;
    logic [c_W1-1:0]  w_step_x;
    logic [c_W1-1:0]  w_lim_x;
    logic [c_W1-1:0]  w_lim1;
    logic [c_W1-1:0]  w_sum;
    logic [c_W1-1:0]  w_wrap_up;
    logic [c_W1-1:0]  w_dpl;
    logic [DATA_WIDTH-1:0] w_step_dw;
    logic [DATA_WIDTH-1:0] w_diff;
    logic [DATA_WIDTH-1:0] w_wrap_dn;
    logic             w_unused_tie;

`ifdef UDCOUNTER_SAT_EN
    assign w_sat_en = sat;
`else
    logic w_unused_sat;
    assign w_unused_sat = sat;
    assign w_sat_en     = 1'b0;
`endif

    assign w_unused_tie = clk_unused_tie;

    assign w_dout_x  = c_W1'(dout);
    assign w_step_x  = c_W1'(step);
    assign w_lim_x   = c_W1'(limit);
    assign w_lim1    = w_lim_x + c_W1'(1);
    assign w_sum     = w_dout_x + w_step_x;
    assign w_wrap_up = w_sum - w_lim1;
    assign w_dpl     = w_dout_x + w_lim1;
    assign w_step_dw = DATA_WIDTH'(step);
    assign w_diff    = dout - w_step_dw;
    // true result is within 0..limit whenever non-negative, so modulo arithmetic is exact
    assign w_wrap_dn = dout + limit + DATA_WIDTH'(1) - w_step_dw;

    always_comb begin
        nxt = dout;
        evt = EV_NONE;
        case (op)
            OP_UP: begin
                if (step != '0) begin
                    if (w_sum <= w_lim_x) begin
                        nxt = w_sum[DATA_WIDTH-1:0];
                    end else begin
                        evt = EV_OVF;
                        if (w_sat_en || (w_wrap_up > w_lim_x))
                            nxt = limit;
                        else
                            nxt = w_wrap_up[DATA_WIDTH-1:0];
                    end
                end
            end
            OP_DOWN: begin
                if (step != '0) begin
                    if (w_dout_x >= w_step_x) begin
                        nxt = w_diff;
                    end else begin
                        evt = EV_UNF;
                        if (w_sat_en || (w_dpl < w_step_x))
                            nxt = '0;
                        else
                            nxt = w_wrap_dn;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/updown_mod_counter.sv
//------------------------------------------------------------------------------
// Module   : updown_mod_counter
// Brief    : Up/down modulo counter with programmable step and limit, wrap or
//            saturate policy (UDCOUNTER_SAT_EN), tc pulses and sticky flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    STEP_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] limit,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  up,
    input  logic                  down,
    input  logic                  sat,
    input  logic                  clr_flags,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  tc_up,
    output logic                  tc_down,
    output logic                  ovf,
    output logic                  unf
);

    counter_op_t           w_op;
    counter_evt_t          w_evt;
    logic [DATA_WIDTH-1:0] w_calc;
    logic [DATA_WIDTH-1:0] w_next;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_tc_up;
    logic                  r_tc_down;
    logic                  r_ovf;
    logic                  r_unf;

    assign w_op = decode_op(load, up, down);

    counter_next_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .STEP_WIDTH (STEP_WIDTH)
    ) u_next_calc (
        .clk_unused_tie (1'b0),
        .op             (w_op),
        .dout           (r_dout),
        .step           (step),
        .limit          (limit),
        .sat            (sat),
        .nxt            (w_calc),
        .evt            (w_evt)
    );

    assign w_next = (w_op == OP_LOAD) ? ((din <= limit) ? din : limit) : w_calc;

    // an event in the same cycle as clr_flags leaves its flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout    <= RESET_VALUE;
            r_tc_up   <= 1'b0;
            r_tc_down <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            r_dout    <= w_next;
            r_tc_up   <= (w_evt == EV_OVF);
            r_tc_down <= (w_evt == EV_UNF);
            r_ovf     <= (w_evt == EV_OVF) || (r_ovf && !clr_flags);
            r_unf     <= (w_evt == EV_UNF) || (r_unf && !clr_flags);
        end
    end

    assign dout    = r_dout;
    assign tc_up   = r_tc_up;
    assign tc_down = r_tc_down;
    assign ovf     = r_ovf;
    assign unf     = r_unf;

endmodule

`default_nettype wire
